wb_arbiter: RTL and testbench
=============================

# wb_arbiter

- Owns the single register-file write port (writeE/writeIdx/writeData) and shares it between two writeback sources.
- Primary source: the in-order pipeline WB stage. It always wins and is never stalled by this block.
- Secondary source: long-latency results (load returns, multi-cycle ALU ops). These go through a small ordered buffer and drain in cycles the primary leaves idle.
- Also provides WAW protection against stale secondary writes, and raises a registered stall request to the pipeline when the secondary source starves.

## Interface

Parameters:
- DEPTH, 2: secondary buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive denied cycles for a valid buffer head before a stall is requested; range 1..15.

Ports:
- clk_in  input  1  clock. Single clock domain; all state updates on posedge.
- rst_in  input  1  reset. Synchronous, active-high (`rstEnable`).
- priE_in  input  1  primary write enable.
- priIdx_in  input  5  primary destination register.
- priData_in  input  32  primary write data.
- secValid_in  input  1  secondary request valid.
- secIdx_in  input  5  secondary destination register.
- secData_in  input  32  secondary write data.
- secReady_out  output  1  buffer can accept a request this cycle.
- writeE_out  output  1  register-file write enable.
- writeIdx_out  output  5  register-file write index.
- writeData_out  output  32  register-file write data.
- stallReq_out  output  1  registered request for the pipeline to withhold primary writes.

## Operation

- Reset (rst_in=1 at posedge): buffer empty, all valid bits cleared, starve counter 0, stallReq_out 0.
- While rst_in=1, writeE_out/writeIdx_out/writeData_out and secReady_out are forced to 0.
- Index 0 writes from either source are discarded:
  - primary: writeE_out stays 0;
  - secondary: the request is accepted (handshake completes) but nothing is stored.
- Grant, combinational:
  - priE_in=1 and priIdx_in≠0: primary drives the port.
  - Otherwise, if the buffer head is valid: the head drives the port and is popped at the edge.
  - Otherwise: writeE_out=0, idx/data=0.
- Invalid (killed) head: popped in any cycle with no write performed, regardless of primary activity.
- Accept: secValid_in & secReady_out at posedge pushes {valid=1, idx, data} at the tail.
  - secReady_out = !full. Depends on state only, never on secValid_in or the pop decision.
  - Push and pop in the same cycle are allowed when not full.
- WAW kill: when the primary writes idx k≠0, every buffered valid entry with idx k has its valid bit cleared at that edge. The primary is always the younger producer.
  - A secondary request accepted in the same cycle with idx k is dropped, not stored.
- Starvation:
  - Counter increments each cycle the head is valid and not granted.
  - Counter clears on a head grant or when the buffer becomes empty.
  - When counter reaches STARVE_LIMIT, stallReq_out is set at the next edge.
  - stallReq_out clears at the edge where the starving head is written or killed.
- stallReq_out is advisory. A primary write asserted during stall still wins; the counter then saturates at STARVE_LIMIT.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; full/empty tracked by an occupancy count 0..DEPTH.

## Timing

- Primary: zero-cycle pass-through, priE_in to writeE_out combinational. The register file's write-first bypass covers same-cycle readers.
- Secondary: earliest write is the cycle after acceptance (1-cycle latency when the port is idle).
- Stall: stallReq_out rises STARVE_LIMIT+1 cycles after the first denied cycle. The pipeline honours it from the following cycle.
- Kill, push, pop and counter updates all take effect at the same posedge.
- A reset asserted mid-drain discards buffered entries with no write.

## Structure

- Additions to the shared defines header:
  - `wbDepth` and `wbStarveLimit` defaults;
  - the buffer-entry field layout: valid, idx[4:0], data[31:0].
- Reuse the existing `regIdxRange`/`dataRange`/`writeEnable` macros.
- One sub-module, wb_fifo: storage, pointers, occupancy, and a per-entry valid-clear port driven by an idx match. Grant, kill generation and starvation logic stay in wb_arbiter.

## Test plan

- Idle port: push sec {x5, 0xA5A5A5A5} with priE=0 → writeE_out=1, idx 5, data 0xA5A5A5A5 exactly one cycle after acceptance; buffer empty afterwards.
- Contention: primary writes x3 every cycle for 6 cycles while sec {x7, 0x11} is buffered (LIMIT=4):
  - writeE_out always carries x3;
  - stallReq_out goes high after 5 denied cycles;
  - once priE drops, x7/0x11 is written and stallReq_out clears the next cycle.
- WAW kill: buffer {x9, 0x1}, then primary writes x9=0x2 → port writes 0x2; the buffered entry is later popped with writeE_out=0, so x9 stays 0x2.
- Full/wrap: DEPTH=2, hold priE=1 to x1, push two sec requests:
  - secReady_out=0 after the second push;
  - release priE → entries drain in order over 2 cycles;
  - ten further push/pop pairs keep order across pointer wrap.
- Index 0: sec {x0, 0xFF} is accepted with no write ever; primary priIdx 0 → writeE_out=0 and a valid buffered head drains that cycle.
- Reset mid-operation: assert rst_in with 2 entries buffered and stallReq_out=1 → next cycle all outputs 0, buffer empty, and no buffered write ever appears.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, defaults and buffer-entry layout for the writeback arbiter
package wb_arbiter_pkg;

  localparam int IDX_W           = 5;
  localparam int DATA_W          = 32;
  localparam int WB_DEPTH        = 2;
  localparam int WB_STARVE_LIMIT = 4;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - ordered secondary writeback buffer with per-entry valid clear on idx match
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic             kill_en,
  input  logic [IDX_W-1:0] kill_idx,
  output wb_entry_t        head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else begin
      // A younger primary write to the same register makes buffered results stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].valid && (mem[i].idx == kill_idx)) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - shares the register-file write port between the pipeline and a buffered secondary source
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              priE_in,
  input  logic [IDX_W-1:0]  priIdx_in,
  input  logic [DATA_W-1:0] priData_in,
  input  logic              secValid_in,
  input  logic [IDX_W-1:0]  secIdx_in,
  input  logic [DATA_W-1:0] secData_in,
  output logic              secReady_out,
  output logic              writeE_out,
  output logic [IDX_W-1:0]  writeIdx_out,
  output logic [DATA_W-1:0] writeData_out,
  output logic              stallReq_out
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_entry_t  head;
  wb_entry_t  push_entry;
  logic       empty;
  logic       full;
  logic       pri_grant;
  logic       head_valid;
  logic       pop;
  logic       push;
  logic       kill_head;
  logic [3:0] starve_cnt;

  assign pri_grant  = priE_in && (priIdx_in != '0);
  assign head_valid = !empty && head.valid;
  // Killed heads leave without a write even while the primary owns the port.
  assign pop        = !empty && (!head.valid || !pri_grant);
  assign kill_head  = pri_grant && head_valid && (head.idx == priIdx_in);

  assign secReady_out = !rst_in && !full;
  assign push         = secValid_in && secReady_out && (secIdx_in != '0)
                        && !(pri_grant && (priIdx_in == secIdx_in));
  assign push_entry   = '{valid: 1'b1, idx: secIdx_in, data: secData_in};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (pri_grant),
    .kill_idx   (priIdx_in),
    .head       (head),
    .empty      (empty),
    .full       (full)
  );

  always_comb begin
    writeE_out    = 1'b0;
    writeIdx_out  = '0;
    writeData_out = '0;
    if (!rst_in) begin
      if (pri_grant) begin
        writeE_out    = 1'b1;
        writeIdx_out  = priIdx_in;
        writeData_out = priData_in;
      end else if (head_valid) begin
        writeE_out    = 1'b1;
        writeIdx_out  = head.idx;
        writeData_out = head.data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt   <= '0;
      stallReq_out <= 1'b0;
    end else begin
      if (!head_valid || pop || kill_head) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      stallReq_out <= head_valid && !pop && !kill_head && (starve_cnt == LIMIT);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with directed writeback scenarios
module tb_wb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        priE_in;
  logic [4:0]  priIdx_in;
  logic [31:0] priData_in;
  logic        secValid_in;
  logic [4:0]  secIdx_in;
  logic [31:0] secData_in;
  logic        secReady_out;
  logic        writeE_out;
  logic [4:0]  writeIdx_out;
  logic [31:0] writeData_out;
  logic        stallReq_out;

  typedef struct {
    int          cyc;
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   c;

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .priE_in       (priE_in),
    .priIdx_in     (priIdx_in),
    .priData_in    (priData_in),
    .secValid_in   (secValid_in),
    .secIdx_in     (secIdx_in),
    .secData_in    (secData_in),
    .secReady_out  (secReady_out),
    .writeE_out    (writeE_out),
    .writeIdx_out  (writeIdx_out),
    .writeData_out (writeData_out),
    .stallReq_out  (stallReq_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every port write must match the next expected write, including its cycle.
  always @(negedge clk_in) begin
    if (writeE_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got idx %0d data %h at cycle %0d, required no write",
                 writeIdx_out, writeData_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.idx != writeIdx_out || e.data != writeData_out) begin
          errors++;
          $display("FAIL write_seq: got cyc %0d idx %0d data %h, required cyc %0d idx %0d data %h",
                   cyc, writeIdx_out, writeData_out, e.cyc, e.idx, e.data);
        end
      end
    end
  end

  task automatic expect_wr(input int at, input logic [4:0] idx, input logic [31:0] data);
    exp_t e;
    e.cyc  = at;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic next();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  task automatic set_pri(input logic e, input logic [4:0] idx, input logic [31:0] data);
    priE_in    = e;
    priIdx_in  = idx;
    priData_in = data;
  endtask

  task automatic set_sec(input logic v, input logic [4:0] idx, input logic [31:0] data);
    secValid_in = v;
    secIdx_in   = idx;
    secData_in  = data;
  endtask

  initial begin
    rst_in = 1'b1;
    set_pri(0, 0, 0);
    set_sec(0, 0, 0);
    next();
    mid();
    check("rst_we", writeE_out, 0);
    check("rst_ready", secReady_out, 0);
    check("rst_stall", stallReq_out, 0);
    next();
    rst_in = 1'b0;
    mid();
    check("post_rst_ready", secReady_out, 1);
    check("post_rst_we", writeE_out, 0);

    // Idle port: one-cycle secondary latency
    next(); c = cyc;
    expect_wr(c + 1, 5, 32'hA5A5A5A5);
    set_sec(1, 5, 32'hA5A5A5A5);
    mid(); check("t1_ready", secReady_out, 1);
    next(); set_sec(0, 0, 0);
    mid(); check("t1_we", writeE_out, 1);
    next();
    mid(); check("t1_idle_we", writeE_out, 0);
    check("t1_ready_after", secReady_out, 1);

    // Contention and starvation stall
    next(); c = cyc;
    for (int i = 0; i < 7; i++) expect_wr(c + i, 3, 32'h300 + i);
    expect_wr(c + 7, 7, 32'h11);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next();
      set_pri(1, 3, 32'h300 + i);
      set_sec(i == 0, 7, 32'h11);
      mid();
      if (i == 5) check("t2_stall_before", stallReq_out, 0);
      if (i == 6) check("t2_stall_high", stallReq_out, 1);
    end
    next(); set_pri(0, 0, 0);
    mid(); check("t2_stall_drain", stallReq_out, 1);
    next();
    mid(); check("t2_stall_clear", stallReq_out, 0);

    // WAW kill, plus same-cycle same-idx secondary drop
    next(); c = cyc;
    expect_wr(c, 2, 32'h22);
    expect_wr(c + 1, 9, 32'h2);
    set_pri(1, 2, 32'h22); set_sec(1, 9, 32'h1);
    next(); set_pri(1, 9, 32'h2); set_sec(1, 9, 32'hBAD);
    mid(); check("t3_ready", secReady_out, 1);
    next(); set_pri(0, 0, 0); set_sec(0, 0, 0);
    mid(); check("t3_killed_no_write", writeE_out, 0);
    next();
    mid(); check("t3_dropped_no_write", writeE_out, 0);
    check("t3_stall", stallReq_out, 0);

    // Full buffer, ordered drain, pointer wrap
    next(); c = cyc;
    expect_wr(c, 1, 32'h1000);
    expect_wr(c + 1, 1, 32'h1001);
    expect_wr(c + 2, 1, 32'h1002);
    expect_wr(c + 3, 10, 32'hA0);
    expect_wr(c + 4, 11, 32'hA1);
    for (int j = 0; j < 10; j++) expect_wr(c + 5 + j, 5'(12 + j), 32'hB0 + j);
    set_pri(1, 1, 32'h1000); set_sec(1, 10, 32'hA0);
    next(); set_pri(1, 1, 32'h1001); set_sec(1, 11, 32'hA1);
    mid(); check("t4_ready_one", secReady_out, 1);
    next(); set_pri(1, 1, 32'h1002); set_sec(0, 0, 0);
    mid(); check("t4_full", secReady_out, 0);
    next(); set_pri(0, 0, 0);
    mid(); check("t4_full_draining", secReady_out, 0);
    for (int j = 0; j < 10; j++) begin
      next(); set_sec(1, 5'(12 + j), 32'hB0 + j);
    end
    next(); set_sec(0, 0, 0);
    next();
    mid(); check("t4_empty_ready", secReady_out, 1);
    check("t4_empty_we", writeE_out, 0);

    // Index 0 from both sources
    next(); set_sec(1, 0, 32'hFF);
    mid(); check("t5_ready", secReady_out, 1);
    next(); set_sec(0, 0, 0);
    mid(); check("t5_no_write", writeE_out, 0);
    next(); c = cyc;
    expect_wr(c, 4, 32'h44);
    expect_wr(c + 1, 6, 32'h66);
    set_pri(1, 4, 32'h44); set_sec(1, 6, 32'h66);
    next(); set_pri(1, 0, 32'hDEAD); set_sec(0, 0, 0);
    mid(); check("t5_head_idx", writeIdx_out, 6);
    next(); set_pri(0, 0, 0);
    mid(); check("t5_idle", writeE_out, 0);

    // Reset mid-operation with two entries and stall raised
    next(); c = cyc;
    for (int i = 0; i < 7; i++) expect_wr(c + i, 2, 32'h200 + i);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next();
      set_pri(1, 2, 32'h200 + i);
      set_sec(i < 2, 5'(13 + i), 32'hC0 + i);
      mid();
      if (i == 6) begin
        check("t6_stall_high", stallReq_out, 1);
        check("t6_full", secReady_out, 0);
      end
    end
    next(); rst_in = 1'b1; set_pri(0, 0, 0); set_sec(0, 0, 0);
    mid(); check("t6_rst_we", writeE_out, 0);
    check("t6_rst_ready", secReady_out, 0);
    check("t6_rst_idx", writeIdx_out, 0);
    check("t6_rst_data", writeData_out, 0);
    next(); rst_in = 1'b0;
    mid(); check("t6_stall_cleared", stallReq_out, 0);
    check("t6_ready_empty", secReady_out, 1);
    check("t6_no_write", writeE_out, 0);
    next(); mid();
    next(); mid();

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
